// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID buffer: owns the PC, registers the fetched word for decode,
// detects load-use hazards and counts stall cycles and redirect flushes.
module if_id_stage #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             clk_BF0,
   input  logic             rst_BF0,
   input  logic [31:0]      instr_BF0_IN,
   input  logic             pcSrc_BF0_IN,
   input  logic [PC_W-1:0]  pcTarget_BF0_IN,
   input  logic             idexMemRead_BF0_IN,
   input  logic [4:0]       idexRt_BF0_IN,
   output logic [PC_W-1:0]  pc_BF0,
   output logic [PC_W-1:0]  nextInst_BF0,
   output logic [31:0]      instruction_BF0,
   output logic             valid_BF0,
   output logic             ctrlBubble_BF0,
   output logic             stall_BF0,
   output logic [CNT_W-1:0] stallCount_BF0,
   output logic [CNT_W-1:0] flushCount_BF0
);

   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [PC_W-1:0] pc_plus4;
   logic [PC_W-1:0] pc_redirect;
   logic            rt_match;

   assign rs          = instruction_BF0[25:21];
   assign rt          = instruction_BF0[20:16];
   assign pc_plus4    = pc_BF0 + PC_W'(4);
   // Target is forced word aligned; the low two bits are masked rather than sliced.
   assign pc_redirect = pcTarget_BF0_IN & ~PC_W'(3);

   // $0 is hardwired zero, so a load into it can never create a real dependency.
   assign rt_match       = (idexRt_BF0_IN != 5'd0) &&
                           ((idexRt_BF0_IN == rs) || (idexRt_BF0_IN == rt));
   assign stall_BF0      = valid_BF0 & idexMemRead_BF0_IN & rt_match;
   assign ctrlBubble_BF0 = stall_BF0 | ~valid_BF0;

   always_ff @(posedge clk_BF0) begin
      if (rst_BF0) begin
         pc_BF0          <= RESET_PC;
         nextInst_BF0    <= '0;
         instruction_BF0 <= 32'h0;
         valid_BF0       <= 1'b0;
         stallCount_BF0  <= '0;
         flushCount_BF0  <= '0;
      end else if (pcSrc_BF0_IN) begin
         pc_BF0          <= pc_redirect;
         nextInst_BF0    <= '0;
         instruction_BF0 <= 32'h0;
         valid_BF0       <= 1'b0;
         if (flushCount_BF0 != '1)
            flushCount_BF0 <= flushCount_BF0 + CNT_W'(1);
      end else if (stall_BF0) begin
         if (stallCount_BF0 != '1)
            stallCount_BF0 <= stallCount_BF0 + CNT_W'(1);
      end else begin
         pc_BF0          <= pc_plus4;
         nextInst_BF0    <= pc_plus4;
         instruction_BF0 <= instr_BF0_IN;
         valid_BF0       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: cycle model compared every negedge,
// plus directed literal checks along the documented scenarios.
module tb_if_id_stage;

   logic        clk_BF0 = 1'b0;
   logic        rst_BF0;
   logic [31:0] instr_BF0_IN;
   logic        pcSrc_BF0_IN;
   logic [7:0]  pcTarget_BF0_IN;
   logic        idexMemRead_BF0_IN;
   logic [4:0]  idexRt_BF0_IN;
   logic [7:0]  pc_BF0;
   logic [7:0]  nextInst_BF0;
   logic [31:0] instruction_BF0;
   logic        valid_BF0;
   logic        ctrlBubble_BF0;
   logic        stall_BF0;
   logic [15:0] stallCount_BF0;
   logic [15:0] flushCount_BF0;

   int checks = 0;
   int errors = 0;

   if_id_stage #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
      .clk_BF0(clk_BF0), .rst_BF0(rst_BF0), .instr_BF0_IN(instr_BF0_IN),
      .pcSrc_BF0_IN(pcSrc_BF0_IN), .pcTarget_BF0_IN(pcTarget_BF0_IN),
      .idexMemRead_BF0_IN(idexMemRead_BF0_IN), .idexRt_BF0_IN(idexRt_BF0_IN),
      .pc_BF0(pc_BF0), .nextInst_BF0(nextInst_BF0), .instruction_BF0(instruction_BF0),
      .valid_BF0(valid_BF0), .ctrlBubble_BF0(ctrlBubble_BF0), .stall_BF0(stall_BF0),
      .stallCount_BF0(stallCount_BF0), .flushCount_BF0(flushCount_BF0)
   );

   always #5 clk_BF0 = ~clk_BF0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state of the stage as plain integers.
   int  m_pc, m_next, m_cnt_stall, m_cnt_flush;
   logic [31:0] m_instr;
   bit  m_valid;
   bit  m_live = 0;

   function automatic bit m_stall();
      int rs_f, rt_f;
      rs_f = int'(m_instr[25:21]);
      rt_f = int'(m_instr[20:16]);
      return m_valid && idexMemRead_BF0_IN === 1'b1 && idexRt_BF0_IN != 0 &&
             (int'(idexRt_BF0_IN) == rs_f || int'(idexRt_BF0_IN) == rt_f);
   endfunction

   always @(posedge clk_BF0) begin
      if (rst_BF0 === 1'b1) begin
         m_pc = 0; m_next = 0; m_instr = 0; m_valid = 0;
         m_cnt_stall = 0; m_cnt_flush = 0; m_live = 1;
      end else if (m_live) begin
         if (pcSrc_BF0_IN) begin
            m_pc = (int'(pcTarget_BF0_IN) / 4) * 4;
            m_next = 0; m_instr = 0; m_valid = 0;
            if (m_cnt_flush < 65535) m_cnt_flush++;
         end else if (m_stall()) begin
            if (m_cnt_stall < 65535) m_cnt_stall++;
         end else begin
            m_pc = (m_pc + 4) % 256;
            m_next = m_pc;
            m_instr = instr_BF0_IN;
            m_valid = 1;
         end
      end
   end

   always @(negedge clk_BF0) begin
      if (m_live) begin
         chk("model_pc",       32'(pc_BF0),          32'(m_pc));
         chk("model_nextInst", 32'(nextInst_BF0),    32'(m_next));
         chk("model_instr",    instruction_BF0,      m_instr);
         chk("model_valid",    32'(valid_BF0),       32'(m_valid));
         chk("model_stall",    32'(stall_BF0),       32'(m_stall()));
         chk("model_bubble",   32'(ctrlBubble_BF0),  32'(m_stall() || !m_valid));
         chk("model_stallCnt", 32'(stallCount_BF0),  32'(m_cnt_stall));
         chk("model_flushCnt", 32'(flushCount_BF0),  32'(m_cnt_flush));
      end
   end

   task automatic tick();
      @(posedge clk_BF0);
      #2;
   endtask

   initial begin
      rst_BF0 = 1; instr_BF0_IN = 32'h8C220004; pcSrc_BF0_IN = 0;
      pcTarget_BF0_IN = 0; idexMemRead_BF0_IN = 0; idexRt_BF0_IN = 0;
      tick(); tick();
      rst_BF0 = 0;
      #1;
      chk("rst_pc", 32'(pc_BF0), 32'h00);
      chk("rst_valid", 32'(valid_BF0), 0);
      chk("rst_bubble", 32'(ctrlBubble_BF0), 1);
      chk("rst_instr", instruction_BF0, 0);
      // Even with a matching-looking ID/EX load, no stall while IF/ID is empty.
      idexMemRead_BF0_IN = 1; idexRt_BF0_IN = 5'd0; #1;
      chk("rst_no_stall", 32'(stall_BF0), 0);
      idexMemRead_BF0_IN = 0;

      // 1: straight-line fetch
      tick();
      chk("t1_pc04", 32'(pc_BF0), 32'h04);
      chk("t1_instr", instruction_BF0, 32'h8C220004);
      chk("t1_next", 32'(nextInst_BF0), 32'h04);
      chk("t1_valid", 32'(valid_BF0), 1);
      tick(); chk("t1_pc08", 32'(pc_BF0), 32'h08);
      tick(); chk("t1_pc0C", 32'(pc_BF0), 32'h0C);
      tick(); chk("t1_pc10", 32'(pc_BF0), 32'h10);

      // 2: load-use on rs=2
      instr_BF0_IN = 32'h00430820;
      tick();
      chk("t2_pc14", 32'(pc_BF0), 32'h14);
      idexMemRead_BF0_IN = 1; idexRt_BF0_IN = 5'd2; #1;
      chk("t2_stall", 32'(stall_BF0), 1);
      chk("t2_bubble", 32'(ctrlBubble_BF0), 1);
      tick();
      chk("t2_pc_hold", 32'(pc_BF0), 32'h14);
      chk("t2_instr_hold", instruction_BF0, 32'h00430820);
      chk("t2_stallcnt", 32'(stallCount_BF0), 1);
      idexMemRead_BF0_IN = 0;
      tick();
      chk("t2_resume", 32'(pc_BF0), 32'h18);

      // 3: $0 never stalls
      instr_BF0_IN = 32'h00000000;
      tick();
      idexMemRead_BF0_IN = 1; idexRt_BF0_IN = 5'd0; #1;
      chk("t3_no_stall", 32'(stall_BF0), 0);
      tick();
      chk("t3_pc", 32'(pc_BF0), 32'h20);
      idexMemRead_BF0_IN = 0;

      // 4: redirect overrides an active stall
      instr_BF0_IN = 32'h00430820;
      tick();
      idexMemRead_BF0_IN = 1; idexRt_BF0_IN = 5'd2; #1;
      chk("t4_stall", 32'(stall_BF0), 1);
      pcSrc_BF0_IN = 1; pcTarget_BF0_IN = 8'h23;
      tick();
      chk("t4_pc", 32'(pc_BF0), 32'h20);
      chk("t4_valid", 32'(valid_BF0), 0);
      chk("t4_instr", instruction_BF0, 0);
      chk("t4_flushcnt", 32'(flushCount_BF0), 1);
      chk("t4_stallcnt", 32'(stallCount_BF0), 1);
      pcSrc_BF0_IN = 0; idexMemRead_BF0_IN = 0;
      instr_BF0_IN = 32'h12345678;
      tick();
      chk("t4_load20", instruction_BF0, 32'h12345678);
      chk("t4_next", 32'(nextInst_BF0), 32'h24);

      // 5: PC wrap
      pcSrc_BF0_IN = 1; pcTarget_BF0_IN = 8'hFE;
      tick();
      chk("t5_pcFC", 32'(pc_BF0), 32'hFC);
      pcSrc_BF0_IN = 0;
      tick();
      chk("t5_wrap_pc", 32'(pc_BF0), 32'h00);
      chk("t5_wrap_next", 32'(nextInst_BF0), 32'h00);

      // 6: reset mid-stall and mid-redirect, then counter saturation
      instr_BF0_IN = 32'h00430820;
      tick();
      idexMemRead_BF0_IN = 1; idexRt_BF0_IN = 5'd2; #1;
      chk("t6_stall", 32'(stall_BF0), 1);
      pcSrc_BF0_IN = 1; pcTarget_BF0_IN = 8'h40; rst_BF0 = 1;
      tick();
      chk("t6_pc", 32'(pc_BF0), 32'h00);
      chk("t6_valid", 32'(valid_BF0), 0);
      chk("t6_stallcnt", 32'(stallCount_BF0), 0);
      chk("t6_flushcnt", 32'(flushCount_BF0), 0);
      rst_BF0 = 0; pcSrc_BF0_IN = 0;
      tick();
      repeat (65541) @(posedge clk_BF0);
      #2;
      chk("t6_saturate", 32'(stallCount_BF0), 32'hFFFF);
      chk("t6_sat_pc", 32'(pc_BF0), 32'h04);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline buffer; sits directly upstream of the ID/EX buffer.
- Holds the 8-bit PC and drives the instruction-memory address.
- Registers the fetched instruction and PC+4 for decode.
- Contains load-use hazard detection, which stalls PC and IF/ID and bubbles the control word entering ID/EX. A taken branch or jump redirects the PC and flushes IF/ID.

Parameters:
- PC_W, 8, PC / nextInst width (byte address, word aligned).
- RESET_PC, 8'h00, PC value after reset.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk_BF0  input  1  clock; all state updates on rising edge.
- rst_BF0  input  1  reset; synchronous, active-high.
- instr_BF0_IN  input  32  instruction from combinational instruction memory at pc_BF0.
- pcSrc_BF0_IN  input  1  taken branch/jump redirect from a later stage.
- pcTarget_BF0_IN  input  PC_W  redirect target; bits [1:0] ignored.
- idexMemRead_BF0_IN  input  1  MemRead bit of the control word currently in ID/EX.
- idexRt_BF0_IN  input  5  rt field currently held in ID/EX.
- pc_BF0  output  PC_W  current PC, the instruction-memory address.
- nextInst_BF0  output  PC_W  registered PC+4 of the decoded instruction; feeds nextInst of ID/EX.
- instruction_BF0  output  32  registered instruction for decode.
- valid_BF0  output  1  IF/ID holds a real instruction.
- ctrlBubble_BF0  output  1  combinational; when 1, decode zeroes the M/EX/WB control into ID/EX.
- stall_BF0  output  1  combinational load-use stall indicator.
- stallCount_BF0  output  CNT_W  stall cycles since reset, saturating.
- flushCount_BF0  output  CNT_W  flush events since reset, saturating.

Behaviour:
- Reset (rst_BF0=1 at a rising edge) sets:
  - pc_BF0 = RESET_PC, nextInst_BF0 = 0, instruction_BF0 = 32'h0 (NOP), valid_BF0 = 0.
  - Both counters = 0.
  - Reset takes priority over every other input, including mid-stall and mid-redirect.
- Field decode of instruction_BF0: rs = [25:21], rt = [20:16].
- Stall (combinational):
  - stall_BF0 = valid_BF0 & idexMemRead_BF0_IN & (idexRt_BF0_IN != 0) & (idexRt_BF0_IN == rs | idexRt_BF0_IN == rt).
  - Register $0 never causes a stall.
- ctrlBubble_BF0 = stall_BF0 | ~valid_BF0.
- Priority per edge (no reset): redirect > stall > normal.
- Redirect (pcSrc_BF0_IN=1), regardless of stall:
  - pc <= {pcTarget_BF0_IN[PC_W-1:2], 2'b00}.
  - IF/ID flushed: instruction <= 0, nextInst <= 0, valid <= 0.
  - flushCount += 1.
  - stallCount unchanged, even if stall_BF0 was 1.
- Stall (stall_BF0=1, no redirect):
  - pc, instruction, nextInst and valid all hold.
  - stallCount += 1.
  - The bubble goes to ID/EX that cycle.
  - The next cycle the ID/EX MemRead has cleared, so the stall lasts exactly one cycle per load-use pair.
- Normal:
  - pc <= pc + 4, wrapping modulo 2^PC_W (8'hFC -> 8'h00).
  - instruction <= instr_BF0_IN, nextInst <= pc + 4 (same wrap), valid <= 1.
- Latency: an instruction fetched at cycle N appears on instruction_BF0 at N+1 and is captured by ID/EX at N+2.
- Counters saturate at all-ones; they never wrap.
- First cycle after reset: valid_BF0=0, so ctrlBubble_BF0=1 and stall_BF0=0 whatever the ID/EX inputs are.

Test Plan:
1. Reset, then 4 cycles with no hazards and instr_BF0_IN = 32'h8C220004 → pc_BF0 = 00, 04, 08, 0C, 10 on successive edges. One cycle after the first fetch, instruction_BF0 = 8C220004, nextInst_BF0 = 04, valid_BF0 = 1.
2. Load-use: IF/ID holds rs=2 (instruction 32'h00430820); set idexMemRead=1, idexRt=2 → stall_BF0 = ctrlBubble_BF0 = 1. pc and IF/ID hold for one edge and stallCount = 1. Then drop idexMemRead → normal advance resumes.
3. idexRt=0 with idexMemRead=1 and rs=0 → no stall; pc advances by 4.
4. Redirect while a stall is active: pcSrc=1, pcTarget=8'h23 → pc = 8'h20, valid_BF0 = 0, instruction_BF0 = 0, flushCount = 1, stallCount unchanged. The next edge loads the instruction at 8'h20.
5. Wrap: pc = 8'hFC with no hazard → pc = 8'h00 and nextInst_BF0 = 8'h00 after the edge.
6. Assert rst_BF0 mid-stall with pcSrc=1 → all outputs return to reset values (pc = RESET_PC, counters 0). Counter saturation is checked by forcing the stall condition for 2^CNT_W + 5 cycles → stallCount = 16'hFFFF.
